// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, flush, hold and bubble counter.
// Define PIPE_STAGE_SKID_EN to add a skid entry behind the main register (2-entry elastic buffer).
module pipe_stage_reg #(
  parameter int unsigned       DATA_W  = 32 * 4,
  parameter logic [DATA_W-1:0] NOP_VAL = '0,
  parameter int unsigned       CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              hold,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic              in_xfer, out_xfer;

  // Hold hides the payload from downstream without disturbing it.
  assign out_valid  = main_valid_q && !hold;
  assign out_data   = main_data_q;
  assign bubble_cnt = bubble_cnt_q;
  assign out_xfer   = out_valid && out_ready;
  assign in_xfer    = in_valid && in_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  // Registered readiness: no combinational path from out_ready.
  assign in_ready = !rst && !flush && !hold && !skid_valid_q;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      main_data_d  = NOP_VAL;
      skid_valid_d = 1'b0;
      skid_data_d  = NOP_VAL;
    end else if (!hold) begin
      if (skid_valid_q) begin
        if (out_xfer) begin
          main_valid_d = 1'b1;
          main_data_d  = skid_data_q;
          skid_valid_d = 1'b0;
          skid_data_d  = NOP_VAL;
        end
      end else if (in_xfer) begin
        if (!main_valid_q || out_xfer) begin
          main_valid_d = 1'b1;
          main_data_d  = in_data;
        end else begin
          skid_valid_d = 1'b1;
          skid_data_d  = in_data;
        end
      end else if (out_xfer) begin
        main_valid_d = 1'b0;
        main_data_d  = NOP_VAL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= NOP_VAL;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end
`else
  assign in_ready = !rst && !flush && !hold && (!main_valid_q || out_ready);

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      main_data_d  = NOP_VAL;
    end else if (!hold) begin
      if (in_xfer) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end else if (out_xfer) begin
        main_valid_d = 1'b0;
        main_data_d  = NOP_VAL;
      end
    end
  end
`endif

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (out_ready && !out_valid && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= NOP_VAL;
      bubble_cnt_q <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg; expectations adapt to PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 128;

  logic          clk = 1'b0;
  logic          rst, in_valid, out_ready, flush, hold;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [15:0]   bubble_cnt;
  logic          s_in_ready, s_out_valid;
  logic [DW-1:0] s_out_data;
  logic [1:0]    s_bubble_cnt;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_q[$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always #5 clk = ~clk;

  pipe_stage_reg u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .hold      (hold),
    .bubble_cnt(bubble_cnt)
  );

  // Narrow counter copy to show saturation.
  pipe_stage_reg #(.CNT_W(2)) u_sat (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .in_data   (in_data),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .out_data  (s_out_data),
    .flush     (flush),
    .hold      (hold),
    .bubble_cnt(s_bubble_cnt)
  );

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // Drive one cycle of inputs just after the edge, then settle to the negedge for checks.
  task automatic drv(input logic iv, input logic [DW-1:0] d, input logic ordy,
                     input logic fl, input logic hd);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    hold      = hd;
    @(negedge clk);
  endtask

  // Monitor: pop on every out transfer; also check payload stability under backpressure.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (!rst) begin
      if (prev_stall && !hold) begin
        chk("stall_valid", DW'(out_valid), DW'(1));
        chk("stall_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: got %0h required no transfer", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e);
        end
      end
    end
    prev_stall = !rst && out_valid && !out_ready && !flush;
    prev_data  = out_data;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = DW'(8'hA5);
    out_ready = 1'b0; flush = 1'b0; hold = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", DW'(out_valid), DW'(0));
    chk("rst_out_data", out_data, DW'(0));
    chk("rst_bubble", DW'(bubble_cnt), DW'(0));
    chk("rst_in_ready", DW'(in_ready), DW'(0));
    chk("rst_sat_bubble", DW'(s_bubble_cnt), DW'(0));

    // Stream 1,2,3 back to back
    exp_q.push_back(DW'(1));
    drv(1, DW'(1), 0, 0, 0);
    chk("s0_in_ready", DW'(in_ready), DW'(1));
    chk("s0_out_valid", DW'(out_valid), DW'(0));
    exp_q.push_back(DW'(2));
    drv(1, DW'(2), 1, 0, 0);
    chk("s1_out_valid", DW'(out_valid), DW'(1));
    chk("s1_in_ready", DW'(in_ready), DW'(1));
    exp_q.push_back(DW'(3));
    drv(1, DW'(3), 1, 0, 0);
    chk("s2_out_valid", DW'(out_valid), DW'(1));
    drv(0, DW'(0), 1, 0, 0);
    chk("s3_out_valid", DW'(out_valid), DW'(1));
    drv(0, DW'(0), 0, 0, 0);
    chk("s4_out_valid", DW'(out_valid), DW'(0));
    chk("stream_bubble", DW'(bubble_cnt), DW'(0));

    // Backpressure: 0x11 stalls for 3 cycles while 0x22 is offered
    exp_q.push_back(DW'(8'h11));
    drv(1, DW'(8'h11), 0, 0, 0);
    drv(1, DW'(8'h22), 0, 0, 0);
    chk("bp1_out_data", out_data, DW'(8'h11));
`ifdef PIPE_STAGE_SKID_EN
    chk("bp1_in_ready", DW'(in_ready), DW'(1));
    exp_q.push_back(DW'(8'h22));
`else
    chk("bp1_in_ready", DW'(in_ready), DW'(0));
`endif
    for (int i = 0; i < 2; i++) begin
      drv(1, DW'(8'h22), 0, 0, 0);
      chk("bp_out_data", out_data, DW'(8'h11));
      chk("bp_in_ready", DW'(in_ready), DW'(0));
    end
    drv(1, DW'(8'h22), 1, 0, 0);
`ifdef PIPE_STAGE_SKID_EN
    chk("bp_rel_in_ready", DW'(in_ready), DW'(0));
`else
    chk("bp_rel_in_ready", DW'(in_ready), DW'(1));
    exp_q.push_back(DW'(8'h22));
`endif
    drv(0, DW'(0), 1, 0, 0);
    chk("bp_second", out_data, DW'(8'h22));
    drv(0, DW'(0), 0, 0, 0);
    chk("bp_empty", DW'(out_valid), DW'(0));
    chk("bp_bubble", DW'(bubble_cnt), DW'(0));

    // Flush with full stage and a new payload offered
    drv(1, DW'(8'h33), 0, 0, 0);
`ifdef PIPE_STAGE_SKID_EN
    drv(1, DW'(8'h44), 0, 0, 0);
`endif
    drv(1, DW'(8'h55), 0, 1, 0);
    chk("fl_in_ready", DW'(in_ready), DW'(0));
    drv(0, DW'(0), 1, 0, 0);
    chk("fl_out_valid", DW'(out_valid), DW'(0));
    chk("fl_out_data", out_data, DW'(0));
    chk("fl_in_ready_after", DW'(in_ready), DW'(1));
    drv(0, DW'(0), 0, 0, 0);
    chk("fl_bubble", DW'(bubble_cnt), DW'(1));

    // Hold for 2 cycles with 0x66 resident
    exp_q.push_back(DW'(8'h66));
    drv(1, DW'(8'h66), 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      drv(0, DW'(0), 1, 0, 1);
      chk("hd_out_valid", DW'(out_valid), DW'(0));
      chk("hd_in_ready", DW'(in_ready), DW'(0));
    end
    drv(0, DW'(0), 0, 0, 0);
    chk("hd_back_valid", DW'(out_valid), DW'(1));
    chk("hd_back_data", out_data, DW'(8'h66));
    drv(0, DW'(0), 1, 0, 0);
    drv(1, DW'(8'h77), 0, 0, 0);
    drv(0, DW'(0), 0, 1, 1);
    drv(0, DW'(0), 0, 0, 0);
    chk("hf_out_valid", DW'(out_valid), DW'(0));
    chk("hf_out_data", out_data, DW'(0));
    chk("hf_bubble", DW'(bubble_cnt), DW'(3));
    chk("hf_sat_bubble", DW'(s_bubble_cnt), DW'(3));

    // Five starved cycles
    for (int i = 0; i < 5; i++) drv(0, DW'(0), 1, 0, 0);
    drv(0, DW'(0), 0, 0, 0);
    chk("bub_cnt", DW'(bubble_cnt), DW'(8));
    chk("bub_sat", DW'(s_bubble_cnt), DW'(3));

    drv(0, DW'(0), 0, 0, 0);
    chk("scoreboard_empty", DW'(exp_q.size()), DW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
